// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard controller for a classic 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
// It keeps a small shadow copy of the pipeline that records only what hazard
// resolution needs: the destination register, whether it is written, and
// whether the instruction is a load or a branch. From that it produces the
// EX-stage operand forwarding selects, the load-use stall, and the wrong-path
// flushes for jumps (resolved in ID) and taken branches (resolved in EX).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   id_valid       ID instruction is real (0 = bubble)
//   Instructions   ID instruction word: rs=[25:21], rt=[20:16], rd=[15:11]
//   RegDst         ID decode: destination is rd (1) or rt (0)
//   RegWr          ID decode: instruction writes the register file
//   MemWr          ID decode: store
//   MemToReg       ID decode: load
//   Branch         ID decode: conditional branch
//   Jump           ID decode: jump
//   Zero           ALU zero flag of the instruction currently in EX
//   ex_forward_a   EX operand A comes from the EX/MEM result   (registered)
//   ex_forward_b   EX operand B comes from the EX/MEM result   (registered)
//   mem_forward_a  EX operand A comes from the MEM/WB result   (registered)
//   mem_forward_b  EX operand B comes from the MEM/WB result   (registered)
//   stall          hold PC and IF/ID this cycle                 (combinational)
//   flush_if_id    clear IF/ID at the next edge                 (combinational)
//   flush_id_ex    load a bubble into ID/EX at the next edge    (combinational)
//   stall_count    saturating count of load-use stall cycles
//   flush_count    saturating count of branch and jump flushes
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      Instructions,
    input  logic             RegDst,
    input  logic             RegWr,
    input  logic             MemWr,
    input  logic             MemToReg,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             Zero,
    output logic             ex_forward_a,
    output logic             ex_forward_b,
    output logic             mem_forward_a,
    output logic             mem_forward_b,
    output logic             stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Shadow of the ID/EX register: the instruction currently executing.
    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
        logic       load;
        logic       br;
    } ex_stage_t;

    // Shadow of the EX/MEM register: the instruction currently in MEM.
    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
    } mem_stage_t;

    // Forwarding selects presented to the datapath during EX.
    typedef struct packed {
        logic ex_a;
        logic ex_b;
        logic mem_a;
        logic mem_b;
    } fwd_sel_t;

    // -------------------------------------------------------------------------
    // ID decode
    // -------------------------------------------------------------------------
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic [4:0] id_dst;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_wr;

    assign id_rs      = Instructions[25:21];
    assign id_rt      = Instructions[20:16];
    assign id_rd      = Instructions[15:11];
    // Jumps carry a target, not a source register, in the rs field.
    assign id_rs_used = id_valid & ~Jump;
    // rt is a source for R-type, stores and branches; otherwise it is the
    // destination of an I-type instruction.
    assign id_rt_used = id_valid & (RegDst | MemWr | Branch);
    assign id_dst     = RegDst ? id_rd : id_rt;
    // Writes to $0 are dropped here so $0 can never be a forwarding source.
    assign id_wr      = id_valid & RegWr & (id_dst != 5'd0);

    // Opcode, shamt and funct do not influence hazards.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instructions[31:26], Instructions[10:0]};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    ex_stage_t        ex_q,        ex_d;
    mem_stage_t       mem_q,       mem_d;
    fwd_sel_t         fwd_q,       fwd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic br_taken;
    logic load_use;
    logic stall_evt;
    logic jump_flush;
    logic kill_id_ex;
    logic flush_evt;

    assign br_taken   = ex_q.br & Zero;
    assign load_use   = ex_q.load & ex_q.wr &
                        ((id_rs_used & (ex_q.dst == id_rs)) |
                         (id_rt_used & (ex_q.dst == id_rt)));
    // A taken branch squashes the dependent instruction anyway, so stalling
    // for it would only waste a cycle.
    assign stall_evt  = load_use & ~br_taken;
    // A jump sitting behind a taken branch is itself wrong-path.
    assign jump_flush = Jump & id_valid & ~stall_evt & ~br_taken;
    assign kill_id_ex = br_taken | stall_evt;
    assign flush_evt  = br_taken | jump_flush;

    assign stall       = ~rst & stall_evt;
    assign flush_if_id = ~rst & flush_evt;
    assign flush_id_ex = ~rst & kill_id_ex;

    // -------------------------------------------------------------------------
    // Forwarding
    // The ID instruction is compared against the one in EX (which will be in
    // MEM, i.e. EX/MEM, when this one executes) and the one in MEM (which will
    // be in WB, i.e. MEM/WB). The younger producer wins. WB-stage producers
    // need nothing: the register file writes before it reads.
    // -------------------------------------------------------------------------
    logic ex_match_a;
    logic ex_match_b;
    logic mem_match_a;
    logic mem_match_b;

    assign ex_match_a  = id_rs_used & ex_q.wr  & (ex_q.dst  == id_rs);
    assign ex_match_b  = id_rt_used & ex_q.wr  & (ex_q.dst  == id_rt);
    assign mem_match_a = id_rs_used & mem_q.wr & (mem_q.dst == id_rs) & ~ex_match_a;
    assign mem_match_b = id_rt_used & mem_q.wr & (mem_q.dst == id_rt) & ~ex_match_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path can leave it holding its old value (which infers a latch).
        mem_d       = '{dst: ex_q.dst, wr: ex_q.wr};
        ex_d        = '{dst:  id_dst,
                        wr:   id_wr,
                        load: id_valid & MemToReg,
                        br:   id_valid & Branch};
        fwd_d       = '{ex_a:  ex_match_a,
                        ex_b:  ex_match_b,
                        mem_a: mem_match_a,
                        mem_b: mem_match_b};
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // A bubble entering EX must neither write nor consume forwarded data.
        if (kill_id_ex) begin
            ex_d  = '0;
            fwd_d = '0;
        end

        if (stall_evt) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        // Branch and jump flushes are mutually exclusive by construction,
        // so a coincident pair is counted once.
        if (flush_evt) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            fwd_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            fwd_q       <= fwd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_forward_a  = fwd_q.ex_a;
    assign ex_forward_b  = fwd_q.ex_b;
    assign mem_forward_a = fwd_q.mem_a;
    assign mem_forward_b = fwd_q.mem_b;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Drives instructions into the ID stage of hazard_forward_unit in assembly
// terms (kind + register numbers) and compares the outputs against directed
// expectations and against a reference model that tracks which instruction
// occupies EX and MEM and what registers it reads and writes.
// A narrow counter width is used so saturation is reached in the random run.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

    localparam int CNT_W = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef enum int {K_NOP, K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_LDBR} kind_e;

    // What the model remembers about an in-flight instruction.
    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
        logic       load;
        logic       br;
    } slot_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [31:0]      Instructions;
    logic             RegDst, RegWr, MemWr, MemToReg, Branch, Jump, Zero;
    logic             ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b;
    logic             stall, flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] stall_count, flush_count;

    hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .Instructions (Instructions),
        .RegDst       (RegDst),
        .RegWr        (RegWr),
        .MemWr        (MemWr),
        .MemToReg     (MemToReg),
        .Branch       (Branch),
        .Jump         (Jump),
        .Zero         (Zero),
        .ex_forward_a (ex_forward_a),
        .ex_forward_b (ex_forward_b),
        .mem_forward_a(mem_forward_a),
        .mem_forward_b(mem_forward_b),
        .stall        (stall),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // {ex_fa, ex_fb, mem_fa, mem_fb, stall, flush_if_id, flush_id_ex}
    logic [6:0] obs;
    assign obs = {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b,
                  stall, flush_if_id, flush_id_ex};

    int checks = 0;
    int errors = 0;

    // Current ID instruction in assembly terms.
    kind_e cur_kind = K_NOP;
    int    cur_rs = 0, cur_rt = 0, cur_rd = 0;

    // Reference model state.
    slot_t       m_ex = '0, m_mem = '0;
    logic [3:0]  m_fwd = '0;            // {ex_a, ex_b, mem_a, mem_b}
    int unsigned m_stall_cnt = 0, m_flush_cnt = 0;
    logic        e_stall, e_fif, e_fie;

    // ------------------------------------------------------------------ model
    function automatic bit reads_rs(kind_e k);
        return k inside {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_LDBR};
    endfunction

    function automatic bit reads_rt(kind_e k);
        return k inside {K_R, K_SW, K_BEQ, K_LDBR};
    endfunction

    function automatic bit produces(slot_t s, int r);
        return s.wr && (int'(s.dst) == r);
    endfunction

    function automatic slot_t id_slot();
        slot_t s;
        int    d;
        s = '0;
        d = (cur_kind == K_R) ? cur_rd : cur_rt;
        s.dst  = 5'(d);
        s.wr   = (cur_kind inside {K_R, K_ADDI, K_LW, K_LDBR}) && d != 0;
        s.load = cur_kind inside {K_LW, K_LDBR};
        s.br   = cur_kind inside {K_BEQ, K_LDBR};
        return s;
    endfunction

    task automatic compute_expect();
        bit br_taken, load_use;
        br_taken = m_ex.br && Zero;
        load_use = m_ex.load && m_ex.wr &&
                   ((reads_rs(cur_kind) && int'(m_ex.dst) == cur_rs) ||
                    (reads_rt(cur_kind) && int'(m_ex.dst) == cur_rt));
        e_stall = !rst && load_use && !br_taken;
        e_fie   = !rst && (br_taken || e_stall);
        e_fif   = !rst && (br_taken || (cur_kind == K_J && !e_stall));
    endtask

    // Advance the model over one rising edge, then the clock itself.
    task automatic tick();
        logic [3:0] fwd;
        compute_expect();
        if (rst) begin
            m_ex = '0; m_mem = '0; m_fwd = '0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            fwd = '0;
            if (reads_rs(cur_kind)) begin
                if (produces(m_ex, cur_rs))       fwd[3] = 1'b1;
                else if (produces(m_mem, cur_rs)) fwd[1] = 1'b1;
            end
            if (reads_rt(cur_kind)) begin
                if (produces(m_ex, cur_rt))       fwd[2] = 1'b1;
                else if (produces(m_mem, cur_rt)) fwd[0] = 1'b1;
            end
            m_mem = m_ex;
            if (e_fie) begin
                m_ex = '0;
                fwd  = '0;
            end else begin
                m_ex = id_slot();
            end
            m_fwd = fwd;
            if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (e_fif   && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------- stimulus
    task automatic issue(input kind_e k, input int rs, input int rt, input int rd);
        cur_kind = k; cur_rs = rs; cur_rt = rt; cur_rd = rd;
        id_valid = (k != K_NOP);
        RegDst   = (k == K_R);
        RegWr    = k inside {K_R, K_ADDI, K_LW, K_LDBR};
        MemWr    = (k == K_SW);
        MemToReg = k inside {K_LW, K_LDBR};
        Branch   = k inside {K_BEQ, K_LDBR};
        Jump     = (k == K_J);
        case (k)
            K_R:    Instructions = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
            K_ADDI: Instructions = {6'h08, 5'(rs), 5'(rt), 16'($urandom)};
            K_LW:   Instructions = {6'h23, 5'(rs), 5'(rt), 16'($urandom)};
            K_SW:   Instructions = {6'h2b, 5'(rs), 5'(rt), 16'($urandom)};
            K_BEQ:  Instructions = {6'h04, 5'(rs), 5'(rt), 16'($urandom)};
            K_J:    Instructions = {6'h02, 26'($urandom)};
            K_LDBR: Instructions = {6'h23, 5'(rs), 5'(rt), 16'($urandom)};
            default: Instructions = $urandom;
        endcase
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        Zero = 1'b0;
        issue(K_NOP, 0, 0, 0);
        #1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst  = 1'b1;
        Zero = 1'b1;
        issue(K_J, 0, 0, 0);       // would flush if reset did not mask it
        #1;
        tick();
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected %b", obs, 7'b0);
        end
        checks++;
        if (stall_count !== '0 || flush_count !== '0) begin
            errors++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d, expected 0 0",
                     stall_count, flush_count);
        end
        rst  = 1'b0;
        Zero = 1'b0;
        issue(K_NOP, 0, 0, 0);
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_release: got %b, expected %b", obs, 7'b0);
        end
        tick();
    endtask

    task automatic test_forward_chain();
        do_reset();
        issue(K_ADDI, 0, 1, 0); #1; tick();   // addi $1,$0,2015
        issue(K_ADDI, 0, 2, 0); #1; tick();   // addi $2,$0,404
        issue(K_R, 1, 2, 1);    #1; tick();   // add  $1,$1,$2
        issue(K_NOP, 0, 0, 0);  #1;
        checks++;
        if (obs !== 7'b0110000) begin
            errors++;
            $display("FAIL chain_add_ex: got %b, expected %b", obs, 7'b0110000);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(K_LW, 0, 3, 0); #1; tick();     // lw  $3,0($0)
        issue(K_R, 3, 0, 5);  #1;             // add $5,$3,$0
        checks++;
        if (obs !== 7'b0000101) begin
            errors++;
            $display("FAIL load_use_stall: got %b, expected %b", obs, 7'b0000101);
        end
        tick();
        issue(K_R, 3, 0, 5);  #1;             // held add re-presented
        checks++;
        if (obs !== 7'b0 || stall_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL load_use_one_cycle: got %b cnt=%0d, expected %b cnt=1",
                     obs, stall_count, 7'b0);
        end
        tick();
        issue(K_NOP, 0, 0, 0); #1;
        checks++;
        if (obs !== 7'b0010000) begin
            errors++;
            $display("FAIL load_use_mem_fwd: got %b, expected %b", obs, 7'b0010000);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        issue(K_ADDI, 0, 1, 0); #1; tick();   // addi $1
        issue(K_BEQ, 3, 4, 0);  #1; tick();   // beq  $3,$4
        issue(K_R, 1, 1, 7);                  // wrong-path add $7,$1,$1
        Zero = 1'b1; #1;
        checks++;
        if (obs !== 7'b0000011) begin
            errors++;
            $display("FAIL branch_taken_flush: got %b, expected %b", obs, 7'b0000011);
        end
        tick();
        Zero = 1'b0;
        issue(K_NOP, 0, 0, 0); #1;
        checks++;
        if (obs !== 7'b0 || flush_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL branch_squashed: got %b cnt=%0d, expected %b cnt=1",
                     obs, flush_count, 7'b0);
        end
        tick();
        issue(K_BEQ, 3, 4, 0); #1; tick();
        issue(K_R, 5, 6, 8);
        Zero = 1'b0; #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL branch_not_taken: got %b, expected %b", obs, 7'b0);
        end
        tick();
        issue(K_NOP, 0, 0, 0); #1;
        checks++;
        if (flush_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL branch_not_taken_count: got %0d, expected 1", flush_count);
        end
        tick();
    endtask

    task automatic test_load_branch();
        do_reset();
        issue(K_LDBR, 0, 4, 0); #1; tick();   // EX holds a load of $4 resolving a branch
        issue(K_R, 4, 4, 9);                  // reads $4
        Zero = 1'b1; #1;
        checks++;
        if (obs !== 7'b0000011) begin
            errors++;
            $display("FAIL load_branch_priority: got %b, expected %b", obs, 7'b0000011);
        end
        tick();
        Zero = 1'b0;
        issue(K_NOP, 0, 0, 0); #1;
        checks++;
        if (stall_count !== '0 || flush_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL load_branch_counts: got stall=%0d flush=%0d, expected 0 1",
                     stall_count, flush_count);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        do_reset();
        issue(K_ADDI, 0, 0, 0); #1; tick();   // addi $0,$0,5
        issue(K_R, 0, 0, 6);    #1; tick();   // add  $6,$0,$0
        issue(K_NOP, 0, 0, 0);  #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL zero_reg_forward: got %b, expected %b", obs, 7'b0);
        end
        tick();
        issue(K_LW, 0, 0, 0); #1; tick();     // lw $0 must not cause a stall
        issue(K_R, 0, 0, 6);  #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL zero_reg_load: got %b, expected %b", obs, 7'b0);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(K_LW, 0, 3, 0); #1; tick();
        issue(K_R, 3, 0, 5);  #1; tick();     // stalls, count -> 1
        issue(K_R, 3, 0, 5);  #1; tick();
        issue(K_LW, 0, 3, 0); #1; tick();
        issue(K_R, 3, 0, 5);
        rst = 1'b1; #1;
        checks++;
        if (obs !== 7'b0 || stall_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL reset_mid_stall_masked: got %b cnt=%0d, expected %b cnt=1",
                     obs, stall_count, 7'b0);
        end
        tick();
        rst = 1'b0; #1;                       // held add re-presented
        checks++;
        if (obs !== 7'b0 || stall_count !== '0 || flush_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall_cleared: got %b stall=%0d flush=%0d, expected %b 0 0",
                     obs, stall_count, flush_count, 7'b0);
        end
        tick();
        issue(K_NOP, 0, 0, 0); #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_stall_reentry: got %b, expected %b", obs, 7'b0);
        end
        tick();
    endtask

    task automatic test_random();
        bit prev_stall, prev_fif;
        do_reset();
        prev_stall = 1'b0;
        prev_fif   = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            Zero = 1'($urandom);
            if (prev_stall)
                issue(cur_kind, cur_rs, cur_rt, cur_rd);
            else if (prev_fif)
                issue(K_NOP, 0, 0, 0);
            else
                issue(kind_e'($urandom_range(0, 6)), $urandom_range(0, 5),
                      $urandom_range(0, 5), $urandom_range(0, 5));
            #1;
            compute_expect();
            checks++;
            if (obs !== {m_fwd, e_stall, e_fif, e_fie}) begin
                errors++;
                $display("FAIL random_outputs[%0d]: got %b, expected %b",
                         i, obs, {m_fwd, e_stall, e_fif, e_fie});
            end
            checks++;
            if (stall_count !== CNT_W'(m_stall_cnt) || flush_count !== CNT_W'(m_flush_cnt)) begin
                errors++;
                $display("FAIL random_counters[%0d]: got stall=%0d flush=%0d, expected %0d %0d",
                         i, stall_count, flush_count, m_stall_cnt, m_flush_cnt);
            end
            prev_stall = e_stall;
            prev_fif   = e_fif;
            tick();
        end
        checks++;
        if (stall_count !== CNT_W'(CNT_MAX) && m_stall_cnt == CNT_MAX) begin
            errors++;
            $display("FAIL random_saturation: got %0d, expected %0d", stall_count, CNT_MAX);
        end
    endtask

    initial begin
        rst = 1'b1;
        Zero = 1'b0;
        issue(K_NOP, 0, 0, 0);
        test_reset();
        test_forward_chain();
        test_load_use();
        test_branch();
        test_load_branch();
        test_zero_reg();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions in its own shadow pipeline and drives the datapath forwarding selects (ex_forward_a/b, mem_forward_a/b).
- Detects load-use hazards and stalls IF/ID one cycle.
- Flushes wrong-path instructions on Jump (resolved in ID) and on taken Branch (resolved in EX).

Parameters:
- CNT_W, 16, width of the saturating stall/flush event counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  the ID-stage instruction is real (0 means bubble).
- Instructions  in  32  ID-stage instruction: rs=[25:21], rt=[20:16], rd=[15:11].
- RegDst  in  1  ID decode: destination is rd (1) or rt (0).
- RegWr  in  1  ID decode: the instruction writes the register file.
- MemWr  in  1  ID decode: store.
- MemToReg  in  1  ID decode: load.
- Branch  in  1  ID decode: conditional branch.
- Jump  in  1  ID decode: jump.
- Zero  in  1  ALU zero flag from the instruction currently in EX.
- ex_forward_a  out  1  EX operand A is taken from the EX/MEM result.
- ex_forward_b  out  1  EX operand B is taken from the EX/MEM result.
- mem_forward_a  out  1  EX operand A is taken from the MEM/WB result.
- mem_forward_b  out  1  EX operand B is taken from the MEM/WB result.
- stall  out  1  hold PC and the IF/ID register this cycle.
- flush_if_id  out  1  clear the IF/ID register at the next edge.
- flush_id_ex  out  1  load a bubble into ID/EX at the next edge.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes plus jump flushes.

Behaviour:
- ID decode (combinational):
  - rs_used = id_valid & ~Jump.
  - rt_used = id_valid & (RegDst | MemWr | Branch).
  - dst = RegDst ? rd : rt.
  - wr = id_valid & RegWr & (dst != 0).
- Shadow pipeline state:
  - ID/EX stage: {ex_dst, ex_wr, ex_load, ex_br}.
  - EX/MEM stage: {mem_dst, mem_wr}.
  - Each edge: EX/MEM <= ID/EX; ID/EX <= ID decode, or all-zero if flush_id_ex.
- Forwarding:
  - Computed in ID against the ID/EX and EX/MEM stage contents.
  - Registered at the same edge the instruction enters EX, so the selects are valid for the whole EX cycle.
  - A-side: ex_forward_a <= rs_used & ex_wr & (ex_dst == rs). mem_forward_a <= rs_used & mem_wr & (mem_dst == rs) & ~(EX-match).
  - B-side: identical, using rt and rt_used.
  - The EX match has priority: ex_* and mem_* are never both 1 for the same operand.
  - Register $0 is never forwarded.
  - WB-stage hazards need no forwarding (the register file writes before it reads).
  - If flush_id_ex is asserted, all four selects register as 0.
- Load-use stall (combinational):
  - load_use = ex_load & ex_wr & ((rs_used & ex_dst == rs) | (rt_used & ex_dst == rt)).
  - stall = load_use & ~br_taken.
  - A stall forces flush_id_ex = 1, which inserts a bubble.
  - After exactly one stall cycle the load is in MEM, and the held instruction enters EX with mem_forward set.
- Branch (combinational):
  - br_taken = ex_br & Zero.
  - When taken: flush_if_id = 1 and flush_id_ex = 1. stall is suppressed and any Jump in ID is ignored.
- Jump:
  - Jump & id_valid & ~stall & ~br_taken gives flush_if_id = 1 only.
  - The jump itself proceeds down the pipe, with wr = 0.
- Counters:
  - stall_count += 1 on each stall cycle.
  - flush_count += 1 on each br_taken or jump flush. A coincident branch and jump counts once.
  - Both saturate at all-ones.
- Reset:
  - Synchronous. At the first edge with rst=1, all shadow state, registered selects and counters go to 0.
  - stall, flush_if_id and flush_id_ex read 0 while rst=1.
  - Reset mid-stall or mid-flush abandons the event; the pipeline restarts empty.

Test Plan:
- Issue addi $1,$0,2015; addi $2,$0,404; add $1,$1,$2 on consecutive cycles -> in the add's EX cycle: ex_forward_b=1, mem_forward_a=1, ex_forward_a=0, mem_forward_b=0, stall=0.
- Issue lw $3,0($0); add $5,$3,$0 -> stall=1 and flush_id_ex=1 for exactly one cycle, stall_count=1; then in the add's EX cycle mem_forward_a=1, ex_forward_a=0.
- Issue beq in ID, then drive Zero=1 during its EX -> flush_if_id=1 and flush_id_ex=1 for one cycle, flush_count increments, no selects set for the squashed instruction. Repeat with Zero=0 -> no flush.
- Issue lw $4 in EX while a beq with Zero=1 is resolving and the ID instruction reads $4 -> stall=0, both flushes asserted, stall_count unchanged.
- Write $0 (addi $0,$0,5) followed by add $6,$0,$0 -> all forward selects stay 0.
- Assert rst for one cycle during a load-use stall -> next cycle all outputs and counters are 0, and the held instruction re-enters with no forwarding.
